// File: rtl/sync_fifo_ext.sv
// sync_fifo_ext: parametrised single-clock FIFO with show-ahead or
// registered read port, occupancy count, almost-full/empty thresholds,
// flush, write-on-full-with-pop and sticky overflow/underflow flags.
// Ports:
//   clk, rst (sync, active-high)
//   wr_en, wr_data               write side
//   rd_en, rd_data, rd_valid     read side (timing set by FWFT)
//   flush                        drop all contents
//   clr_err                      clear sticky error flags
//   count, full, empty, almost_full, almost_empty   status from registered state
//   overflow, underflow          sticky error flags
module sync_fifo_ext #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 8,
    parameter int AF_THRESH  = 6,
    parameter int AE_THRESH  = 1,
    parameter int FWFT       = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wr_en,
    input  logic [DATA_WIDTH-1:0]   wr_data,
    input  logic                    rd_en,
    output logic [DATA_WIDTH-1:0]   rd_data,
    output logic                    rd_valid,
    input  logic                    flush,
    input  logic                    clr_err,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    full,
    output logic                    empty,
    output logic                    almost_full,
    output logic                    almost_empty,
    output logic                    overflow,
    output logic                    underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    if (DATA_WIDTH < 1) begin : g_bad_width
        $fatal(1, "sync_fifo_ext: DATA_WIDTH must be >= 1");
    end
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $fatal(1, "sync_fifo_ext: DEPTH must be a power of 2, >= 2");
    end
    if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_bad_af
        $fatal(1, "sync_fifo_ext: AF_THRESH out of range");
    end
    if (AE_THRESH < 0 || AE_THRESH > DEPTH - 1) begin : g_bad_ae
        $fatal(1, "sync_fifo_ext: AE_THRESH out of range");
    end
    if (FWFT != 0 && FWFT != 1) begin : g_bad_fwft
        $fatal(1, "sync_fifo_ext: FWFT must be 0 or 1");
    end

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] count_q;
    logic [AW-1:0] wr_idx;
    logic [AW-1:0] rd_idx;
    logic          rd_acc;
    logic          wr_acc;
    logic          overflow_q;
    logic          underflow_q;

    assign wr_idx = wr_ptr[AW-1:0];
    assign rd_idx = rd_ptr[AW-1:0];

    assign count        = count_q;
    assign empty        = (count_q == '0);
    assign full         = (count_q == PW'(DEPTH));
    assign almost_full  = (count_q >= PW'(AF_THRESH));
    assign almost_empty = (count_q <= PW'(AE_THRESH));

    // A write into a full FIFO is fine when the head is popped on the same
    // edge: the freed slot is the one being written.
    assign rd_acc = rd_en & ~empty;
    assign wr_acc = wr_en & (~full | rd_acc);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else if (flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (wr_acc && !rd_acc) begin
                count_q <= count_q + 1'b1;
            end else if (rd_acc && !wr_acc) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && !flush && wr_acc) begin
            mem[wr_idx] <= wr_data;
        end
    end

    // A new error in the same cycle as clr_err keeps the flag set.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (!flush && wr_en && !wr_acc) begin
                overflow_q <= 1'b1;
            end else if (clr_err) begin
                overflow_q <= 1'b0;
            end
            if (!flush && rd_en && empty) begin
                underflow_q <= 1'b1;
            end else if (clr_err) begin
                underflow_q <= 1'b0;
            end
        end
    end

    assign overflow  = overflow_q;
    assign underflow = underflow_q;

    if (FWFT == 1) begin : g_fwft
        assign rd_data  = mem[rd_idx];
        assign rd_valid = ~empty;
    end else begin : g_reg
        logic [DATA_WIDTH-1:0] rd_data_q;
        logic                  rd_valid_q;

        always_ff @(posedge clk) begin
            if (rst) begin
                rd_data_q  <= '0;
                rd_valid_q <= 1'b0;
            end else if (flush) begin
                rd_valid_q <= 1'b0;
            end else begin
                rd_valid_q <= rd_acc;
                if (rd_acc) begin
                    rd_data_q <= mem[rd_idx];
                end
            end
        end

        assign rd_data  = rd_data_q;
        assign rd_valid = rd_valid_q;
    end

endmodule
